vecmat_dot_pipe: RTL
====================

VECMAT_DOT_PIPE -- requirements
Module: vecmat_dot_pipe

Interface
REQ-001 SHALL provide parameter DW, default 16, signed fixed-point element width.
REQ-002 SHALL provide parameter FRAC, default 8, fractional bits of DW format.
REQ-003 SHALL provide parameter LANES, default 64, elements per beat, power of two, 2..256.
REQ-004 SHALL provide parameter AW, default 2*DW+clog2(LANES)+8, accumulator width.
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, beat offered.
REQ-008 SHALL have port in_ready, output, 1, beat accepted when in_valid&&in_ready at clk edge.
REQ-009 SHALL have port in_last, input, 1, beat closes the current dot product.
REQ-010 SHALL have port vector, input, LANES*DW, lane i at [i*DW+:DW].
REQ-011 SHALL have port matrix, input, LANES*DW, lane i at [i*DW+:DW].
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, result consumed when out_valid&&out_ready.
REQ-014 SHALL have port data_out, output, DW, saturated dot-product result.
REQ-015 SHALL have port out_sat, output, 1, result clipped somewhere in its computation.
REQ-016 SHALL have port out_beats, output, 8, beats in this result, saturating at 255.

Function
REQ-017 SHALL compute per lane the full-precision 2*DW signed product vector[i]*matrix[i], registered (stage M).
REQ-018 SHALL reduce LANES products in a binary adder tree, one register per level, clog2(LANES) stages, full precision, no internal truncation.
REQ-019 SHALL add each tree sum into an AW-bit signed accumulator, saturating at AW limits with a sticky overflow bit.
REQ-020 SHALL, for a beat tagged in_last, load acc+sum into the output register, then clear acc, sticky bit and beat counter in the same cycle.
REQ-021 SHALL form data_out as (acc+sum)>>>FRAC (arithmetic, truncating toward -inf), clipped to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 SHALL set out_sat when the final clip or the sticky accumulator overflow applied.
REQ-023 SHALL give latency clog2(LANES)+2 cycles from accepting an in_last beat to out_valid, with no stalls.
REQ-024 SHALL accept one beat per cycle; back-to-back dot products with no gap SHALL be supported, including single-beat products.
REQ-025 SHALL freeze the whole pipeline (M, tree, acc, counter) while out_valid&&!out_ready; in_ready = !(out_valid&&!out_ready), combinational.
REQ-026 SHALL hold data_out, out_sat and out_beats stable while out_valid&&!out_ready.
REQ-027 SHALL clear out_valid on handshake unless a new result loads in the same cycle.
REQ-028 SHALL carry per-stage valid and last bits; bubbles (in_valid=0) SHALL NOT alter acc.

Reset
REQ-029 SHALL, on reset low, asynchronously clear all stage valids, acc, sticky bit and beat counter; out_valid=0, data_out=0, out_sat=0, out_beats=0.
REQ-030 SHALL discard in-flight partial products on reset mid-operation; the first post-reset result SHALL contain only post-reset beats.
REQ-031 SHALL drive in_ready=1 during and after reset while no result is pending.

Verification (LANES=4, DW=16, FRAC=8, latency 4)
REQ-032 All vector=0x0100, matrix=0x0200, in_last=1, one beat -> data_out=0x0800, out_sat=0, out_beats=1, out_valid 4 cycles after accept.
REQ-033 Same operands, three consecutive beats, last on third -> data_out=0x1800, out_beats=3.
REQ-034 vector=0xFF00, matrix=0x0100, single beat -> data_out=0xFC00, out_sat=0.
REQ-035 vector=matrix=0x7FFF, single beat -> data_out=0x7FFF, out_sat=1; vector=0x8000, matrix=0x7FFF -> data_out=0x8000, out_sat=1.
REQ-036 Two back-to-back single-beat products, out_ready=0 for 5 cycles -> in_ready=0 while held, first result stable, both results delivered in order after out_ready=1.
REQ-037 Reset pulsed after two non-last beats, then one 0x0100x0x0200 last beat -> data_out=0x0800, out_beats=1.

Source files
------------

// File: rtl/vecmat_dot_pipe.sv
// vecmat_dot_pipe: streamed fixed-point dot product with pipelined adder tree and saturating accumulator
module vecmat_dot_pipe #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 64,
  parameter int AW    = 2*DW+$clog2(LANES)+8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] vector,
  input  logic [LANES*DW-1:0] matrix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       data_out,
  output logic                out_sat,
  output logic [7:0]          out_beats
);
  localparam int LG = $clog2(LANES);
  localparam int PW = 2*DW;
  localparam int SW = PW+LG;
  localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW-1:0] DMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] DMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic                 w_adv;
  logic signed [PW-1:0] w_prod [LANES];
  logic signed [PW-1:0] r_m_prod [LANES];
  logic signed [SW-1:0] r_node [1:LANES-1];
  logic signed [SW-1:0] w_node [1:2*LANES-1];
  logic [LG:0]          r_v, r_l;
  logic signed [AW-1:0] r_acc, r_f_acc, w_acc_n, w_shift;
  logic signed [AW:0]   w_add;
  logic                 r_sticky, r_f_sticky, r_f_v, w_ovf, w_sticky_n, w_hi, w_lo;
  logic [7:0]           r_cnt, r_f_beats, w_cnt_n;
  // a held result freezes every stage; nothing moves until it is taken
  assign in_ready = !(out_valid && !out_ready);
  assign w_adv    = in_ready;
  // lane products and heap-ordered tree wiring: node k sums nodes 2k and 2k+1, leaves at LANES..2*LANES-1
  always_comb begin
    for (int j = 0; j < LANES; j++)
      w_prod[j] = $signed({{DW{vector[j*DW+DW-1]}}, vector[j*DW+:DW]}) *
                  $signed({{DW{matrix[j*DW+DW-1]}}, matrix[j*DW+:DW]});
    for (int j = 1; j < LANES; j++)
      w_node[j] = r_node[j];
    for (int j = 0; j < LANES; j++)
      w_node[LANES+j] = $signed({{LG{r_m_prod[j][PW-1]}}, r_m_prod[j]});
  end
  // product stage plus valid/last tags shifting alongside the tree levels
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int j = 0; j < LANES; j++) r_m_prod[j] <= '0;
      r_v <= '0;
      r_l <= '0;
    end else if (w_adv) begin
      for (int j = 0; j < LANES; j++) r_m_prod[j] <= w_prod[j];
      r_v <= {r_v[LG-1:0], in_valid};
      r_l <= {r_l[LG-1:0], in_valid && in_last};
    end
  // adder tree: every node registered, so all leaves reach the root after LG cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int j = 1; j < LANES; j++) r_node[j] <= '0;
    else if (w_adv)
      for (int j = 1; j < LANES; j++) r_node[j] <= w_node[2*j] + w_node[2*j+1];
  assign w_add      = $signed({r_acc[AW-1], r_acc}) + $signed({{(AW+1-SW){w_node[1][SW-1]}}, w_node[1]});
  assign w_ovf      = w_add[AW] ^ w_add[AW-1];
  assign w_acc_n    = w_ovf ? (w_add[AW] ? AMIN : AMAX) : w_add[AW-1:0];
  assign w_sticky_n = r_sticky | w_ovf;
  assign w_cnt_n    = r_cnt == 8'hFF ? r_cnt : r_cnt + 8'd1;
  // accumulate valid sums; a last beat hands the total to the final stage and restarts the accumulator
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
      r_f_v      <= 1'b0;
      r_f_acc    <= '0;
      r_f_sticky <= 1'b0;
      r_f_beats  <= '0;
    end else if (w_adv) begin
      r_f_v <= r_v[LG] && r_l[LG];
      if (r_v[LG] && r_l[LG]) begin
        r_f_acc    <= w_acc_n;
        r_f_sticky <= w_sticky_n;
        r_f_beats  <= w_cnt_n;
        r_acc      <= '0;
        r_sticky   <= 1'b0;
        r_cnt      <= '0;
      end else if (r_v[LG]) begin
        r_acc    <= w_acc_n;
        r_sticky <= w_sticky_n;
        r_cnt    <= w_cnt_n;
      end
    end
  assign w_shift = r_f_acc >>> FRAC;
  assign w_hi    = w_shift > DMAX;
  assign w_lo    = w_shift < DMIN;
  // output register: scale, clip to DW and hold while the consumer stalls
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else if (w_adv) begin
      out_valid <= r_f_v;
      if (r_f_v) begin
        data_out  <= w_hi ? DMAX[DW-1:0] : w_lo ? DMIN[DW-1:0] : w_shift[DW-1:0];
        out_sat   <= w_hi | w_lo | r_f_sticky;
        out_beats <= r_f_beats;
      end
    end
endmodule
